// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Imported by the top level and by the division step.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Shifts the next dividend bit into the remainder and tries a subtract.
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Keep the difference when it does not borrow, otherwise restore.
    always_comb begin
        trial = {rem, quot[WIDTH-1]};
        diff  = trial - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next  = diff[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = trial[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed MULT (radix-2 Booth) / DIV (restoring) unit.
// One FSM, one counter and shared working registers serve both ops.
module mult_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fin_q, fin_d;
    logic             op_q, op_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] wq_q, wq_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic             qm1_q, qm1_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mc_ext, sum;
    logic [WIDTH-1:0] rem_nx, quot_nx;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem       (acc_q[WIDTH-1:0]),
        .quot      (wq_q),
        .divisor   (mc_q),
        .rem_next  (rem_nx),
        .quot_next (quot_nx)
    );

    // Operand magnitudes and the Booth add/subtract for this iteration.
    always_comb begin
        abs_a  = a[WIDTH-1] ? -a : a;
        abs_b  = b[WIDTH-1] ? -b : b;
        mc_ext = {mc_q[WIDTH-1], mc_q};
        unique case ({wq_q[0], qm1_q})
            2'b01:   sum = acc_q + mc_ext;
            2'b10:   sum = acc_q - mc_ext;
            default: sum = acc_q;
        endcase
    end

    // Control FSM plus datapath next-state; hi/lo written only on DONE entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        op_d    = op_q;
        acc_d   = acc_q;
        wq_d    = wq_q;
        mc_d    = mc_q;
        qm1_d   = qm1_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    fin_d = 1'b0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    dz_d  = 1'b0;
                    if (op == OP_DIV && b == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        if (op == OP_DIV) begin
                            wq_d   = abs_a;
                            mc_d   = abs_b;
                            qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
                            rneg_d = a[WIDTH-1];
                        end else begin
                            wq_d = b;
                            mc_d = a;
                        end
                    end
                end
            end
            RUN: begin
                if (!fin_q) begin
                    if (op_q == OP_DIV) begin
                        acc_d = {1'b0, rem_nx};
                        wq_d  = quot_nx;
                    end else begin
                        acc_d = {sum[WIDTH], sum[WIDTH:1]};
                        wq_d  = {sum[0], wq_q[WIDTH-1:1]};
                        qm1_d = wq_q[0];
                    end
                    if (cnt_q == CNT_LAST) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = DONE;
                    if (op_q == OP_DIV) begin
                        lo_d = qneg_q ? -wq_q : wq_q;
                        hi_d = rneg_q ? -acc_q[WIDTH-1:0]
                                      : acc_q[WIDTH-1:0];
                    end else begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = wq_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and working registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            op_q    <= OP_MULT;
            acc_q   <= '0;
            wq_q    <= '0;
            mc_q    <= '0;
            qm1_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            wq_q    <= wq_d;
            mc_q    <= mc_d;
            qm1_q   <= qm1_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = done & dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit.
// Expected results come from plain signed 64-bit arithmetic.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Signed product, or truncating quotient/remainder; b==0 keeps hi/lo.
    task automatic model(input logic o, input logic [31:0] av,
                         input logic [31:0] bv,
                         inout logic [31:0] h, inout logic [31:0] l,
                         output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        dz = 1'b0;
        if (o == 1'b0) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (bv == 32'd0) begin
            dz = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endtask

    // One operation: start, bounded wait for done, compare, post-done idle.
    task automatic run_op(input logic o, input logic [31:0] av,
                          input logic [31:0] bv, input bit disturb,
                          input string tag);
        logic [31:0] eh, el;
        logic ed;
        int cyc;
        int exp_cyc;
        eh = exp_hi;
        el = exp_lo;
        model(o, av, bv, eh, el, ed);
        exp_cyc = ed ? 0 : 33;
        start = 1'b1;
        op = o;
        a = av;
        b = bv;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 1'($urandom);
        check({tag, " busy"}, 64'(busy), 64'(1));
        cyc = 0;
        while (!done && cyc < 40) begin
            if (disturb) begin
                start = (cyc == 4);
                op = 1'($urandom);
                a = $urandom;
                b = (cyc == 4) ? 32'd0 : $urandom;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " div_zero"}, 64'(div_zero), 64'(ed));
        exp_hi = eh;
        exp_lo = el;
        if (disturb) begin
            start = 1'b1;
            op = 1'b1;
            a = $urandom;
            b = 32'd0;
        end
        tick();
        start = 1'b0;
        check({tag, " done_pulse"}, 64'(done), 64'(0));
        check({tag, " idle"}, 64'(busy), 64'(0));
        if (disturb) begin
            tick();
            check({tag, " no_restart"}, 64'({busy, done}), 64'(0));
            check({tag, " hold_hi"}, 64'(hi), 64'(eh));
            check({tag, " hold_lo"}, 64'(lo), 64'(el));
        end
    endtask

    initial begin
        logic        o;
        logic [31:0] av, bv;
        int          sel;
        n_checks = 0;
        n_pass = 0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        reset = 1'b0;
        start = 1'b0;
        op = 1'b0;
        a = 32'd0;
        b = 32'd0;
        #3;
        check("reset outputs", 64'({busy, done, div_zero}), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mult 7*-3");
        check("mult 7*-3 hi const", 64'(exp_hi), 64'(32'hFFFF_FFFF));
        check("mult 7*-3 lo const", 64'(exp_lo), 64'(32'hFFFF_FFEB));
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult min*min");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
        run_op(1'b1, 32'd5, 32'd0, 1'b0, "div 5/0");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1");
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "mult disturb");
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, "div disturb");

        start = 1'b1;
        op = 1'b1;
        a = 32'h7654_3210;
        b = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        check("abort hi", 64'(hi), 64'(0));
        check("abort lo", 64'(lo), 64'(0));
        check("abort busy/done", 64'({busy, done}), 64'(0));
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("after abort idle", 64'({busy, done}), 64'(0));
        run_op(1'b1, 32'hFFFF_FC18, 32'd7, 1'b0, "div after reset");

        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom);
            av = $urandom;
            bv = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) bv = 32'd0;
            if (sel == 1) bv = 32'hFFFF_FFFF;
            if (sel == 2) av = 32'h8000_0000;
            if (sel == 3) bv = $urandom_range(1, 9);
            if (sel == 4) bv = 32'h8000_0000;
            run_op(o, av, bv, (sel == 5), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
